mult_pipe_hs: RTL

//  Parametrised pipelined shift-add multiplier: N x M operands, BPS multiplier bits per stage.
//  Per-transaction signed/unsigned mode and a tag carried with each product.

---
 rtl/mult_pipe_hs_if.sv | 30 +++
 rtl/mult_pipe_hs.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mult_pipe_hs_if.sv
// Handshake bundle for mult_pipe_hs: input transaction, product return and busy flag.
interface mult_pipe_hs_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 8,
  parameter int unsigned TAGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic            in_sgn;
  logic [N-1:0]    in_a;
  logic [M-1:0]    in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [N+M-1:0]  out_res;
  logic [TAGW-1:0] out_tag;
  logic            busy;

  // Producer/consumer side (drives operands, accepts products).
  modport master (
    output in_valid, in_sgn, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_sgn, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, busy
  );
endinterface

// File: rtl/mult_pipe_hs.sv
// Pipelined shift-add multiplier, BPS multiplier bits per stage, signed/unsigned per
// transaction, tag carried alongside, valid/ready with bubble-collapsing backpressure.
module mult_pipe_hs #(
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 8,
  parameter int unsigned BPS  = 2,
  parameter int unsigned TAGW = 4
) (
  input  logic          clk,
  input  logic          rst,
  mult_pipe_hs_if.slave bus
);

  localparam int unsigned S = M / BPS;
  localparam int unsigned W = N + M;

  // Multiplier width must split evenly into stages.
  if ((M % BPS) != 0) begin : g_bad_bps
    $error("mult_pipe_hs: M must be a multiple of BPS");
  end

  // Stage registers: valid, shifted multiplicand, remaining multiplier bits,
  // partial accumulator (final stage holds the signed-corrected product), sign, tag.
  logic [S-1:0]    v_q;
  logic [W-1:0]    mc_q  [S];
  logic [M-1:0]    mb_q  [S];
  logic [W-1:0]    acc_q [S];
  logic            neg_q [S];
  logic [TAGW-1:0] tag_q [S];

  // Values presented to each stage's load port.
  logic [S-1:0]    src_v;
  logic [W-1:0]    src_mc  [S];
  logic [M-1:0]    src_mb  [S];
  logic [W-1:0]    src_acc [S];
  logic            src_neg [S];
  logic [TAGW-1:0] src_tag [S];
  logic [W-1:0]    sum_c   [S];
  logic [S-1:0]    ld_c;

  logic [N-1:0] a_mag_c;
  logic [M-1:0] b_mag_c;
  logic         neg_in_c;

  // Operand magnitudes and product sign for signed transactions.
  assign a_mag_c  = (bus.in_sgn && bus.in_a[N-1]) ? N'(-bus.in_a) : bus.in_a;
  assign b_mag_c  = (bus.in_sgn && bus.in_b[M-1]) ? M'(-bus.in_b) : bus.in_b;
  assign neg_in_c = bus.in_sgn & (bus.in_a[N-1] ^ bus.in_b[M-1]);

  // Load-enable chain: a stage loads if it is empty or its successor loads.
  always_comb begin
    logic [S-1:0] rdy;
    rdy      = '0;
    rdy[S-1] = ~v_q[S-1] | bus.out_ready;
    for (int k = int'(S) - 2; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
    ld_c = rdy;
  end

  // Source of each stage: input port for stage 0, previous stage otherwise.
  always_comb begin
    src_v      = '0;
    src_v[0]   = bus.in_valid;
    src_mc[0]  = W'(a_mag_c);
    src_mb[0]  = b_mag_c;
    src_acc[0] = '0;
    src_neg[0] = neg_in_c;
    src_tag[0] = bus.in_tag;
    for (int unsigned k = 1; k < S; k++) begin
      src_v[k]   = v_q[k-1];
      src_mc[k]  = mc_q[k-1];
      src_mb[k]  = mb_q[k-1];
      src_acc[k] = acc_q[k-1];
      src_neg[k] = neg_q[k-1];
      src_tag[k] = tag_q[k-1];
    end
  end

  // Per-stage partial sum over the BPS multiplier bits it consumes.
  always_comb begin
    logic [W-1:0] acc;
    for (int unsigned k = 0; k < S; k++) begin
      acc = src_acc[k];
      for (int unsigned j = 0; j < BPS; j++) begin
        if (src_mb[k][j]) acc = acc + (src_mc[k] << j);
      end
      sum_c[k] = acc;
    end
  end

  // Pipeline advance; data fields only update when a valid transaction moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < S; k++) begin
        mc_q[k]  <= '0;
        mb_q[k]  <= '0;
        acc_q[k] <= '0;
        neg_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < S; k++) begin
        if (ld_c[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            mc_q[k]  <= src_mc[k] << BPS;
            mb_q[k]  <= src_mb[k] >> BPS;
            acc_q[k] <= (k == S - 1 && src_neg[k]) ? W'(-sum_c[k]) : sum_c[k];
            neg_q[k] <= src_neg[k];
            tag_q[k] <= src_tag[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = ld_c[0] & ~rst;
  assign bus.out_valid = v_q[S-1];
  assign bus.out_res   = acc_q[S-1];
  assign bus.out_tag   = tag_q[S-1];
  assign bus.busy      = |v_q;

endmodule
